// File: rtl/weight_packer.sv
// Packs a stream of signed WIDTH-bit weights into WIDTH*WORDS rows for the 30-row weight store.
// Latency: rowWe/rowData/rowAddr appear the cycle after the last handshake of a row.
// Backpressure: readyOut comes from state only; high throughout PACK, one word per cycle, no bubbles.
module weight_packer #(
    parameter int WIDTH = 10,
    parameter int WORDS = 32,
    parameter int ROWS  = 30
) (
    input  logic                   Clock,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic [WIDTH-1:0]       dataIn,
    input  logic                   validIn,
    output logic                   readyOut,
    output logic [WIDTH*WORDS-1:0] rowData,
    output logic [4:0]             rowAddr,
    output logic                   rowWe,
    output logic                   done,
    output logic [9:0]             count0,
    output logic [9:0]             count1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PACK = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [WIDTH*WORDS-1:0] asm_buf;
    logic [WIDTH*WORDS-1:0] asm_next;
    logic                   hs;
    logic                   row_last;
    logic                   pass_last;

    // readyOut is a pure state decode so it never combinationally depends on validIn
    assign readyOut  = (state == PACK);
    assign hs        = readyOut && validIn;
    assign row_last  = (count0 == 10'(WORDS - 1));
    assign pass_last = (count1 == 10'(ROWS - 1));

    // Assembly buffer with the incoming word dropped into its slot (raw bits, word 0 in LSBs)
    always_comb begin
        asm_next = asm_buf;
        for (int k = 0; k < WORDS; k++) begin
            if (count0 == 10'(k)) begin
                asm_next[k*WIDTH +: WIDTH] = dataIn;
            end
        end
    end

    // Pass sequencing, row assembly and the one-cycle row write strobe
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            asm_buf <= '0;
            rowData <= '0;
            rowAddr <= '0;
            rowWe   <= 1'b0;
            done    <= 1'b0;
            count0  <= '0;
            count1  <= '0;
        end else begin
            rowWe <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= PACK;
                        count0  <= '0;
                        count1  <= '0;
                        asm_buf <= '0;
                    end
                end
                PACK: begin
                    if (hs) begin
                        if (row_last) begin
                            // rowData is its own register, so the next row can start immediately
                            rowData <= asm_next;
                            rowAddr <= count1[4:0];
                            rowWe   <= 1'b1;
                            count0  <= '0;
                            count1  <= count1 + 10'd1;
                            asm_buf <= '0;
                            if (pass_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            asm_buf <= asm_next;
                            count0  <= count0 + 10'd1;
                        end
                    end
                end
                DONE: begin
                    if (!Start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_packer.sv
// Directed bench for weight_packer: reset, single row, gapped signed row, full pass, mid-row reset.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Row strobes are logged by a monitor on the falling edge.
module tb_weight_packer;

    localparam int W  = 10;
    localparam int N  = 32;
    localparam int R  = 30;
    localparam int RW = W * N;

    logic          Clock = 1'b0;
    logic          Rst = 1'b0;
    logic          Start = 1'b0;
    logic [W-1:0]  dataIn = '0;
    logic          validIn = 1'b0;
    logic          readyOut;
    logic [RW-1:0] rowData;
    logic [4:0]    rowAddr;
    logic          rowWe;
    logic          done;
    logic [9:0]    count0;
    logic [9:0]    count1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [RW-1:0] log_dat [0:127];
    logic [4:0]    log_addr[0:127];
    int            log_cyc [0:127];
    int            nlog = 0;

    weight_packer #(.WIDTH(W), .WORDS(N), .ROWS(R)) dut (
        .Clock   (Clock),
        .Rst     (Rst),
        .Start   (Start),
        .dataIn  (dataIn),
        .validIn (validIn),
        .readyOut(readyOut),
        .rowData (rowData),
        .rowAddr (rowAddr),
        .rowWe   (rowWe),
        .done    (done),
        .count0  (count0),
        .count1  (count1)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (rowWe && nlog < 128) begin
            log_dat[nlog]  <= rowData;
            log_addr[nlog] <= rowAddr;
            log_cyc[nlog]  <= cyc;
            nlog           <= nlog + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [RW-1:0] fill(input logic [W-1:0] v);
        logic [RW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = v;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"},   RW'(readyOut), RW'(0));
        chk({tag, "_we"},      RW'(rowWe),    RW'(0));
        chk({tag, "_done"},    RW'(done),     RW'(0));
        chk({tag, "_rowdata"}, rowData,       RW'(0));
        chk({tag, "_rowaddr"}, RW'(rowAddr),  RW'(0));
        chk({tag, "_count0"},  RW'(count0),   RW'(0));
        chk({tag, "_count1"},  RW'(count1),   RW'(0));
    endtask

    initial begin
        logic [RW-1:0] exp_row;
        int base;

        // Reset held low: everything at zero
        Rst = 1'b0;
        step();
        step();
        check_idle_outputs("rst");

        // Release reset and request a pass; ready one cycle after the sampling edge
        Rst   = 1'b1;
        Start = 1'b1;
        step();
        chk("start_ready",  RW'(readyOut), RW'(1));
        chk("start_count0", RW'(count0),   RW'(0));
        chk("start_count1", RW'(count1),   RW'(0));

        // Single row, word k = k, back-to-back
        base = nlog;
        for (int k = 0; k < N; k++) begin
            exp_row[k*W +: W] = W'(k);
            dataIn  = W'(k);
            validIn = 1'b1;
            step();
            if (k < N - 1) chk("row0_no_we", RW'(rowWe), RW'(0));
        end
        chk("row0_we",     RW'(rowWe),   RW'(1));
        chk("row0_addr",   RW'(rowAddr), RW'(0));
        chk("row0_data",   rowData,      exp_row);
        chk("row0_count0", RW'(count0),  RW'(0));
        chk("row0_count1", RW'(count1),  RW'(1));
        validIn = 1'b0;
        step();
        chk("row0_we_drop",   RW'(rowWe),   RW'(0));
        chk("row0_data_hold", rowData,      exp_row);
        chk("row0_nstrobe",   RW'(nlog - base), RW'(1));
        step();
        chk("idle_valid_count0", RW'(count0), RW'(0));

        // Signed -1 words with validIn toggling: 32 accepted over 64 cycles
        base = nlog;
        for (int i = 0; i < 64; i++) begin
            validIn = (i % 2 == 0);
            dataIn  = 10'h3FF;
            step();
            chk("gap_we", RW'(rowWe), RW'(i == 62));
        end
        validIn = 1'b0;
        step();
        chk("gap_nstrobe", RW'(nlog - base), RW'(1));
        chk("gap_data",    log_dat[base],    {RW{1'b1}});
        chk("gap_addr",    RW'(log_addr[base]), RW'(1));
        chk("gap_count1",  RW'(count1),      RW'(2));

        // Fresh pass for the full 960-word run
        Rst = 1'b0;
        step();
        Rst   = 1'b1;
        Start = 1'b1;
        step();
        base = nlog;
        for (int i = 0; i < N * R; i++) begin
            dataIn  = 10'd200;
            validIn = 1'b1;
            step();
            if (i < N * R - 1) chk("full_not_done", RW'(done), RW'(0));
        end
        chk("full_done",     RW'(done),     RW'(1));
        chk("full_ready_lo", RW'(readyOut), RW'(0));
        chk("full_last_we",  RW'(rowWe),    RW'(1));
        chk("full_last_adr", RW'(rowAddr),  RW'(29));
        chk("full_count1",   RW'(count1),   RW'(30));
        // A 961st word offered while DONE must be refused
        step();
        chk("full_nstrobe",  RW'(nlog - base), RW'(30));
        chk("full_we_after", RW'(rowWe),    RW'(0));
        chk("full_count0_x", RW'(count0),   RW'(0));
        chk("full_count1_x", RW'(count1),   RW'(30));
        for (int j = 0; j < R; j++) begin
            chk("full_addr", RW'(log_addr[base + j]), RW'(j));
            chk("full_data", log_dat[base + j], fill(10'd200));
            if (j > 0) chk("full_spacing", RW'(log_cyc[base + j] - log_cyc[base + j - 1]), RW'(32));
        end
        validIn = 1'b0;
        step();
        chk("done_holds", RW'(done), RW'(1));
        Start = 1'b0;
        step();
        chk("back_idle_done",  RW'(done),     RW'(0));
        chk("back_idle_ready", RW'(readyOut), RW'(0));

        // Reset in the middle of row 3
        Start = 1'b1;
        step();
        chk("mid_ready", RW'(readyOut), RW'(1));
        base = nlog;
        for (int i = 0; i < 3 * N + 15; i++) begin
            dataIn  = 10'd5;
            validIn = 1'b1;
            step();
        end
        chk("mid_count0", RW'(count0), RW'(15));
        chk("mid_count1", RW'(count1), RW'(3));
        Rst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        validIn = 1'b0;
        Start   = 1'b0;
        step();
        Rst   = 1'b1;
        Start = 1'b1;
        step();
        chk("restart_ready", RW'(readyOut), RW'(1));
        for (int i = 0; i < N; i++) begin
            dataIn  = 10'd7;
            validIn = 1'b1;
            step();
        end
        validIn = 1'b0;
        step();
        chk("restart_nstrobe", RW'(nlog - base), RW'(4));
        chk("restart_pre0",    RW'(log_addr[base]),     RW'(0));
        chk("restart_pre2",    RW'(log_addr[base + 2]), RW'(2));
        chk("restart_addr",    RW'(log_addr[base + 3]), RW'(0));
        chk("restart_data",    log_dat[base + 3],       fill(10'd7));
        chk("restart_count1",  RW'(count1), RW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_packer.md
# weight_packer

Packs a stream of signed 10-bit weights into 320-bit rows and writes them, row by row, into the 30-row weight store that `DrowsinessDetector` reads during weight initialization. It is the write-side counterpart of the initializer's unpack path. Trained or updated weights leave the network datapath one word per cycle through a valid/ready handshake and are rebuilt into the exact row format the initializer consumes.

## Interface
- `WIDTH`, 10, bits per weight word (two's complement).
- `WORDS`, 32, words per row; row width is `WIDTH*WORDS` = 320.
- `ROWS`, 30, rows per pass.
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Rst` in 1: reset is asynchronous and active-low.
- `Start` in 1: level request to begin a packing pass.
- `dataIn` in `WIDTH`: signed weight word.
- `validIn` in 1: `dataIn` is valid this cycle.
- `readyOut` out 1: block accepts a word this cycle.
- `rowData` out `WIDTH*WORDS`: assembled row.
- `rowAddr` out 5: row index of `rowData`, 0..`ROWS`-1.
- `rowWe` out 1: one-cycle write strobe for `rowData`/`rowAddr`.
- `done` out 1: pass complete.
- `count0` out 10: words accepted in the current row, 0..`WORDS`-1.
- `count1` out 10: rows completed in this pass, 0..`ROWS`.

## Operation
- A handshake occurs on a rising edge when `validIn` and `readyOut` are both 1.
- The state machine has three states:
  - IDLE: `readyOut`=0. Moves to PACK on the edge where `Start`=1. On entry, `count0`, `count1` and the assembly buffer are cleared.
  - PACK: `readyOut`=1. Each handshake stores `dataIn` at assembly bits [`count0`*`WIDTH` +: `WIDTH`] (word 0 in the LSBs) and increments `count0`.
    - The word is stored as raw bits, with no sign extension or saturation.
    - `Start` is ignored while in PACK.
  - DONE: `readyOut`=0 and `done`=1. Moves to IDLE on the edge where `Start`=0, which clears `done`.
- Row completion, on the handshake with `count0`=`WORDS`-1:
  - The full row, including the current word, is loaded into the `rowData` register.
  - `rowAddr` is set to `count1` and `rowWe` is set to 1 for the next cycle only.
  - `count0` wraps to 0, `count1` increments, and the assembly buffer clears.
- PACK runs with no bubble. Accepting the first word of the next row is legal in the same cycle that `rowWe` is high, because `rowData` is a separate register from the assembly buffer.
- When `count1` reaches `ROWS`, the state moves to DONE on that same edge.
- `rowData` and `rowAddr` hold their values between strobes.
- Reset, including reset mid-pass, forces:
  - state IDLE;
  - `readyOut`, `rowWe` and `done` to 0;
  - `rowData`, `rowAddr`, `count0`, `count1` and the assembly buffer to 0.
  - A partial row is discarded and never written.

## Timing
- `readyOut` is decoded from state only and does not depend on `validIn`.
- It rises one cycle after the edge that samples `Start`=1 in IDLE.
- Throughput is one word per cycle. A full pass takes 960 handshakes; with `validIn` held at 1 it takes 960 PACK cycles.
- Row write latency: `rowWe` is high during the cycle after the 32nd handshake of a row.
- Last row:
  - `rowWe` (`rowAddr`=29) and `done` both rise after the 960th handshake.
  - `readyOut` falls on that same edge, so a 961st word is never accepted.
- When `validIn`=0 in PACK, no counters change and `rowWe` stays 0.
- Counter updates are visible the cycle after the handshake that causes them.

## Test plan
- Reset and start:
  - Hold `Rst`=0 → all outputs 0.
  - Release reset, set `Start`=1 → `readyOut`=1 one cycle later, `count0`=`count1`=0.
- Single row:
  - Feed words 0..31 with value = index, `validIn` always 1.
  - → `rowWe` pulses once, `rowAddr`=0, and `rowData` bits [10k+9:10k] = k.
  - → `count0`=0, `count1`=1.
- Signed data and gaps:
  - Feed 32 words of -1 (0x3FF) with `validIn` toggling every cycle.
  - → `rowData` is all ones, `rowWe` pulses only after the 32nd accepted word, 64 cycles elapse.
- Full pass:
  - Feed 960 words of 200 back-to-back.
  - → 30 `rowWe` pulses, exactly 32 cycles apart, with `rowAddr` 0..29 in order.
  - → `done`=1 with the last strobe, `readyOut`=0 afterwards.
  - → dropping `Start` returns the block to IDLE with `done`=0.
- Reset mid-row:
  - Assert `Rst` low after 15 words of row 3 → outputs clear immediately.
  - After restart, row 0 is rewritten from fresh data, and no write to `rowAddr`=3 occurs from the aborted row.
